// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between NUM_REQUESTERS producers, the arbiter and one FIFO write port.
// master = arbiter, slave = producers plus the FIFO.
interface fifo_write_arbiter_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQUESTERS = 4
) ();
  logic [NUM_REQUESTERS-1:0]            req_valid;
  logic [NUM_REQUESTERS-1:0]            req_last;
  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQUESTERS-1:0]            req_ready;
  logic                                 fifo_full;
  logic [DATA_WIDTH-1:0]                fifo_data_in;
  logic                                 fifo_write_enable;
  logic [NUM_REQUESTERS-1:0]            grant;
  logic [7:0]                           burst_count;

  modport master (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_data_in, fifo_write_enable, grant, burst_count
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_data_in, fifo_write_enable, grant, burst_count
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQUESTERS valid/ready producers,
// with bounded bursts and a same-cycle stall on fifo_full.
module fifo_write_arbiter_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  owner,
  input  logic                  full,
  input  logic                  valid,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  take,
  output logic                  own_valid,
  output logic                  own_last,
  output logic [DATA_WIDTH-1:0] data_m
);
  assign ready     = owner & ~full;
  assign take      = valid & ready;
  assign own_valid = owner & valid;
  assign own_last  = owner & last;
  assign data_m    = owner ? data : '0;
endmodule

module fifo_write_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQUESTERS = 4,
  parameter int MAX_BURST      = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  fifo_write_arbiter_if.master bus
);
  localparam int         N  = NUM_REQUESTERS;
  localparam int         IW = $clog2(N);
  localparam logic [7:0] MB = 8'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;

  logic          armed_q;
  logic [N-1:0]  grant_q;
  logic [IW-1:0] last_q;
  logic [7:0]    bc_q;

  logic [N-1:0]                 owner, ready, take, own_v, own_l, win_oh;
  logic [N-1:0][DATA_WIDTH-1:0] data_m;
  logic [DATA_WIDTH-1:0]        data_or;
  logic [IW-1:0]                winner, cand;
  logic found, in_burst, accept, owner_valid, owner_last, burst_done, release_g, arb_start;

  assign in_burst = (state_q == BURST);
  assign owner    = in_burst ? grant_q : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    fifo_write_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .owner     (owner[i]),
      .full      (bus.fifo_full),
      .valid     (bus.req_valid[i]),
      .last      (bus.req_last[i]),
      .data      (bus.req_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .ready     (ready[i]),
      .take      (take[i]),
      .own_valid (own_v[i]),
      .own_last  (own_l[i]),
      .data_m    (data_m[i])
    );
  end

  assign accept      = |take;
  assign owner_valid = |own_v;
  assign owner_last  = |own_l;
  assign burst_done  = accept && (owner_last || (bc_q + 8'd1 == MB));
  // A full FIFO freezes the burst; only an idle owner with room available gives up the port.
  assign release_g   = in_burst && (burst_done || (!bus.fifo_full && !owner_valid));
  // armed_q keeps the first edge after reset release in IDLE without arbitrating.
  assign arb_start   = (state_q == IDLE) && armed_q && (|bus.req_valid);

  always_comb begin
    winner = last_q;
    cand   = last_q;
    found  = 1'b0;
    win_oh = '0;
    for (int k = 0; k < N; k++) begin
      cand = (cand == IW'(N-1)) ? '0 : cand + IW'(1);
      if (!found && bus.req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
    win_oh[winner] = 1'b1;
  end

  always_comb begin
    data_or = '0;
    for (int i = 0; i < N; i++) data_or |= data_m[i];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_start) state_d = BURST;
      BURST:   if (release_g) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed_q <= 1'b0;
      grant_q <= '0;
      last_q  <= IW'(N-1);
      bc_q    <= '0;
    end else begin
      armed_q <= 1'b1;
      if (arb_start) begin
        grant_q <= win_oh;
        last_q  <= winner;
        bc_q    <= '0;
      end else if (in_burst) begin
        if (accept)    bc_q    <= bc_q + 8'd1;
        if (release_g) grant_q <= '0;
      end
    end
  end

  always_comb begin
    bus.req_ready         = ready;
    bus.fifo_write_enable = accept;
    bus.fifo_data_in      = data_or;
    bus.grant             = grant_q;
    bus.burst_count       = bc_q;
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomised and directed bench for fifo_write_arbiter: producer queues feed a scoreboard,
// and a monitor checks every write, grant decision and burst end against arbitration rules.
module tb_fifo_write_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fifo_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQUESTERS(NR)) bus ();

  fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQUESTERS(NR), .MAX_BURST(MB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int         tests = 0;
  int         fails = 0;
  logic [8:0] pend [NR][$];
  logic [7:0] expq [NR][$];
  int         win_log[$];
  int         burst_log[$];
  int         bc_max = 0;
  bit         rnd = 1'b0;
  bit         force_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit l);
    pend[i].push_back({l, d});
    expq[i].push_back(d);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NR; i++) s += pend[i].size();
    return s;
  endfunction

  function automatic int queued();
    int s = 0;
    for (int i = 0; i < NR; i++) s += expq[i].size();
    return s;
  endfunction

  // Producers: drive at negedge, fifo_full at +3, observe handshake just before posedge.
  initial begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NR; i++) begin
        bus.req_valid[i] = (pend[i].size() > 0) && (!rnd || $urandom_range(3) != 0);
        if (pend[i].size() > 0) begin
          bus.req_last[i]           = pend[i][0][8];
          bus.req_data[i*DW +: DW]  = pend[i][0][7:0];
        end else begin
          bus.req_last[i]           = 1'($urandom_range(1));
          bus.req_data[i*DW +: DW]  = 8'($urandom);
        end
      end
      #3;
      bus.fifo_full = rnd ? ($urandom_range(3) == 0) : force_full;
      #1;
      for (int i = 0; i < NR; i++)
        if (reset && bus.req_valid[i] && bus.req_ready[i]) void'(pend[i].pop_front());
    end
  end

  // Monitor / reference model
  logic [NR-1:0] mg, pv, g;
  bit            pacc, plast, pfull, idle1, rel;
  int            cnt, lastw, w, idx;

  initial begin
    mg = '0; pv = '0; pacc = 0; plast = 0; pfull = 0; idle1 = 0; cnt = 0; lastw = NR-1;
    forever begin
      @(negedge clock);
      #4;
      if (!reset) begin
        mg = '0; pv = '0; pacc = 0; plast = 0; pfull = 0; idle1 = 0; cnt = 0; lastw = NR-1;
      end else begin
        g = bus.grant;
        if (int'(bus.burst_count) > bc_max) bc_max = int'(bus.burst_count);
        if (mg != '0) begin
          rel = (pacc && (plast || cnt == MB)) || (!pfull && (pv & mg) == '0);
          if (rel) begin
            burst_log.push_back(cnt);
            mg    = '0;
            idle1 = 1;
          end
          chk("grant", g, mg);
        end else begin
          if (g != '0 || (idle1 && pv != '0)) begin
            w = -1;
            for (int k = 1; k <= NR; k++)
              if (w < 0 && pv[(lastw + k) % NR]) w = (lastw + k) % NR;
            if (w < 0) chk("spurious_grant", g, 0);
            else begin
              mg    = '0;
              mg[w] = 1'b1;
              lastw = w;
              cnt   = 0;
              win_log.push_back(w);
              chk("winner", g, mg);
            end
          end
          idle1 = 0;
        end
        chk("ready", bus.req_ready, bus.fifo_full ? '0 : mg);
        chk("write_enable", bus.fifo_write_enable,
            mg != '0 && !bus.fifo_full && (bus.req_valid & mg) != '0);
        if (mg != '0) chk("burst_count", bus.burst_count, cnt);
        else          chk("idle_data", bus.fifo_data_in, 0);
        pacc = 0;
        if (bus.fifo_write_enable && mg != '0) begin
          idx = 0;
          for (int i = 0; i < NR; i++) if (mg[i]) idx = i;
          chk("write_has_word", expq[idx].size() > 0, 1);
          if (expq[idx].size() > 0) chk("data", bus.fifo_data_in, expq[idx].pop_front());
          plast = bus.req_last[idx];
          cnt++;
          pacc = 1;
        end
        pv    = bus.req_valid;
        pfull = bus.fifo_full;
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    #1 reset = 1'b0;
    win_log.delete();
    burst_log.delete();
    bc_max = 0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
    repeat (3) @(negedge clock);
    chk("all_words_written", queued(), 0);
  endtask

  task automatic wait_for(input logic [NR-1:0] gr, input int bc);
    int n = 0;
    do begin
      @(negedge clock);
      #2;
      n++;
    end while (!(bus.grant == gr && bus.burst_count == 8'(bc)) && n < 100);
    chk("target_burst_reached", n < 100, 1);
  endtask

  initial begin
    int sp_exp[3] = '{4, 4, 2};
    int pk_exp[3] = '{2, 1, 1};
    int pw_exp[3] = '{1, 3, 0};

    // reset state with a producer already valid
    for (int k = 0; k < 10; k++) push(0, 8'(k), k == 9);
    #12;
    chk("rst_grant", bus.grant, 0);
    chk("rst_burst_count", bus.burst_count, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_write_enable", bus.fifo_write_enable, 0);
    chk("rst_data", bus.fifo_data_in, 0);

    // single producer, bursts of 4,4,2
    release_reset();
    drain(300);
    chk("sp_burst_total", burst_log.size(), 3);
    for (int k = 0; k < 3; k++)
      chk("sp_burst_len", k < burst_log.size() ? burst_log[k] : -1, sp_exp[k]);
    chk("sp_peak_count", bc_max, 4);

    // round robin, all continuously valid
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int s = 0; s < 8; s++) push(i, 8'(i*16 + s), 1'b0);
    release_reset();
    drain(500);
    chk("rr_grant_total", win_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("rr_winner", k < win_log.size() ? win_log[k] : -1, k % NR);
      chk("rr_burst_len", k < burst_log.size() ? burst_log[k] : -1, MB);
    end

    // FIFO full stall mid-burst
    do_reset();
    for (int s = 0; s < 8; s++) push(2, 8'(8'h40 + s), s == 7);
    release_reset();
    wait_for(4'b0100, 2);
    force_full = 1'b1;
    #2;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        @(negedge clock);
        #4;
      end
      chk("stall_ready", bus.req_ready, 0);
      chk("stall_write_enable", bus.fifo_write_enable, 0);
      chk("stall_grant", bus.grant, 4'b0100);
      chk("stall_burst_count", bus.burst_count, 2);
    end
    force_full = 1'b0;
    drain(300);
    chk("stall_burst_total", burst_log.size(), 2);

    // packet end and valid drop
    do_reset();
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b1);
    release_reset();
    drain(200);
    #1;
    push(3, 8'h31, 1'b0);
    push(0, 8'h01, 1'b1);
    drain(200);
    for (int k = 0; k < 3; k++) begin
      chk("pkt_burst_len", k < burst_log.size() ? burst_log[k] : -1, pk_exp[k]);
      chk("pkt_winner", k < win_log.size() ? win_log[k] : -1, pw_exp[k]);
    end

    // asynchronous reset mid-burst
    do_reset();
    for (int s = 0; s < 6; s++) push(1, 8'(8'h20 + s), s == 5);
    release_reset();
    wait_for(4'b0010, 3);
    reset = 1'b0;
    #1;
    chk("async_grant", bus.grant, 0);
    chk("async_write_enable", bus.fifo_write_enable, 0);
    chk("async_burst_count", bus.burst_count, 0);
    chk("async_ready", bus.req_ready, 0);
    win_log.delete();
    push(0, 8'h05, 1'b1);
    @(negedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 chk("first_edge_grant", bus.grant, 0);
    @(posedge clock);
    #1 chk("second_edge_grant", bus.grant, 4'b0001);
    drain(200);
    chk("async_first_winner", win_log.size() > 0 ? win_log[0] : -1, 0);

    // randomized traffic with random valid gaps and fifo_full
    do_reset();
    rnd = 1'b1;
    for (int i = 0; i < NR; i++)
      for (int s = 0; s < 20; s++) push(i, 8'(i*64 + s), $urandom_range(2) == 0);
    release_reset();
    drain(4000);
    rnd = 1'b0;
    chk("rnd_grants_seen", win_log.size() >= NR, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
